// File: rtl/gat_run_ctrl.sv
// Run sequencer for the GAT accelerator: waits for all host BRAM loads, runs conv1 then conv2, then
// raises gat_ready and hands the new-feature BRAM to the host. Optional watchdog: define GAT_WDOG_EN.
module gat_run_ctrl #(
  parameter int unsigned TOP_WIDTH   = 32,
  parameter int unsigned WDOG_CYCLES = 50000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 h_data_bram_load_done,
  input  logic                 h_node_info_bram_load_done,
  input  logic                 wgt_bram_load_done,
  input  logic                 subgraph_bram_load_done,
  input  logic                 soft_clr,
  output logic                 conv1_start,
  input  logic                 conv1_done,
  output logic                 conv2_start,
  input  logic                 conv2_done,
  output logic                 feat_rd_grant,
  output logic                 gat_ready,
  output logic [TOP_WIDTH-1:0] gat_debug_1,
  output logic [TOP_WIDTH-1:0] gat_debug_2,
  output logic [TOP_WIDTH-1:0] gat_debug_3
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START1 = 3'd1,
    RUN1   = 3'd2,
    START2 = 3'd3,
    RUN2   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t               state, state_nxt;
  logic [3:0]           flags;
  logic [TOP_WIDTH-1:0] cnt1, cnt2;
  logic [7:0]           run_cnt;
  logic                 wdog_exp;
  logic                 wdog_err;
  logic                 clr_ok;

  assign clr_ok = soft_clr && ((state == DONE) || (state == ERR));

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (&flags) state_nxt = START1;
      START1: state_nxt = RUN1;
      RUN1: begin
        if (conv1_done)    state_nxt = START2;
        else if (wdog_exp) state_nxt = ERR;
      end
      START2: state_nxt = RUN2;
      RUN2: begin
        if (conv2_done)    state_nxt = DONE;
        else if (wdog_exp) state_nxt = ERR;
      end
      DONE, ERR: if (soft_clr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      flags         <= '0;
      cnt1          <= '0;
      cnt2          <= '0;
      run_cnt       <= '0;
      conv1_start   <= 1'b0;
      conv2_start   <= 1'b0;
      gat_ready     <= 1'b0;
      feat_rd_grant <= 1'b0;
    end else begin
      state <= state_nxt;
      // A load_done arriving together with an accepted soft_clr belongs to the old run and is dropped.
      if (clr_ok) flags <= '0;
      else        flags <= flags | {subgraph_bram_load_done, wgt_bram_load_done,
                                    h_node_info_bram_load_done, h_data_bram_load_done};
      if (state == START1) begin
        cnt1 <= '0;
        cnt2 <= '0;
      end else begin
        if (state == RUN1 && cnt1 != '1) cnt1 <= cnt1 + TOP_WIDTH'(1);
        if (state == RUN2 && cnt2 != '1) cnt2 <= cnt2 + TOP_WIDTH'(1);
      end
      if (state == RUN2 && conv2_done) run_cnt <= run_cnt + 8'd1;
      // Outputs decode the next state so they line up with the state they belong to.
      conv1_start   <= (state_nxt == START1);
      conv2_start   <= (state_nxt == START2);
      gat_ready     <= (state_nxt == DONE);
      feat_rd_grant <= (state_nxt == DONE);
    end
  end

`ifdef GAT_WDOG_EN
  localparam logic [TOP_WIDTH-1:0] WDOG_LAST = TOP_WIDTH'(WDOG_CYCLES - 1);
  logic [TOP_WIDTH-1:0] wdog_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (state == START1 || state == START2)  wdog_cnt <= '0;
      else if (state == RUN1 || state == RUN2) wdog_cnt <= wdog_cnt + TOP_WIDTH'(1);
      if (clr_ok)                  wdog_err <= 1'b0;
      else if (state_nxt == ERR)   wdog_err <= 1'b1;
    end
  end

  // Expiry is only consulted after the matching done, so a coincident done wins.
  assign wdog_exp = (wdog_cnt == WDOG_LAST);
`else
  logic wdog_unused;
  assign wdog_unused = (WDOG_CYCLES != 0);
  assign wdog_exp    = 1'b0;
  assign wdog_err    = 1'b0;
`endif

  assign gat_debug_1 = {{(TOP_WIDTH-16){1'b0}}, run_cnt, wdog_err, flags, state};
  assign gat_debug_2 = cnt1;
  assign gat_debug_3 = cnt2;

endmodule
